// File: rtl/onchip_mem_arbiter_if.sv
// rtl/onchip_mem_arbiter_if.sv - Avalon-MM style master port bundle for onchip_mem_arbiter
interface onchip_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   address;
  logic                read;
  logic                write;
  logic [DATA_W/8-1:0] byteenable;
  logic [DATA_W-1:0]   writedata;
  logic                waitrequest;
  logic [DATA_W-1:0]   readdata;
  logic                readdatavalid;
  logic [1:0]          response;
`ifdef ONCHIP_MEM_ARB_LOCK_EN
  logic                lock;
`endif

  modport master (
`ifdef ONCHIP_MEM_ARB_LOCK_EN
    output lock,
`endif
    output address, read, write, byteenable, writedata,
    input  waitrequest, readdata, readdatavalid, response
  );

  modport slave (
`ifdef ONCHIP_MEM_ARB_LOCK_EN
    input  lock,
`endif
    input  address, read, write, byteenable, writedata,
    output waitrequest, readdata, readdatavalid, response
  );
endinterface

// File: rtl/onchip_mem_arbiter.sv
// rtl/onchip_mem_arbiter.sv - two-master round-robin arbiter for a single-port on-chip RAM
// Optional bus locking is compiled in with ONCHIP_MEM_ARB_LOCK_EN.
module onchip_mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32,
  parameter int DEPTH  = 37500
) (
  input  logic                clk,
  input  logic                reset_n,
  onchip_mem_arbiter_if.slave m0,
  onchip_mem_arbiter_if.slave m1,
  output logic [ADDR_W-1:0]   mem_address,
  output logic                mem_chipselect,
  output logic                mem_write,
  output logic                mem_clken,
  output logic [DATA_W/8-1:0] mem_byteenable,
  output logic [DATA_W-1:0]   mem_writedata,
  input  logic [DATA_W-1:0]   mem_readdata,
  output logic                err_oor
);
  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(DEPTH);

  logic              elig0, elig1, grant0, grant1, any_grant, sel;
  logic              sel_write, in_range, last_grant;
  logic [ADDR_W-1:0] sel_address;
  logic              rsp_valid, rsp_id, rsp_err;
  logic              block0, block1;

`ifdef ONCHIP_MEM_ARB_LOCK_EN
  typedef enum logic [1:0] {LK_FREE, LK_M0, LK_M1} lock_t;
  lock_t lock_state, lock_next;
  logic  sel_lock;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) lock_state <= LK_FREE;
    else          lock_state <= lock_next;
  end

  // Only the owner can be granted while locked, so any unlocked accepted access frees the bus.
  always_comb begin
    lock_next = lock_state;
    sel_lock  = sel ? m1.lock : m0.lock;
    if (any_grant) lock_next = sel_lock ? (sel ? LK_M1 : LK_M0) : LK_FREE;
  end

  assign block0 = (lock_state == LK_M1);
  assign block1 = (lock_state == LK_M0);
`else
  assign block0 = 1'b0;
  assign block1 = 1'b0;
`endif

  always_comb begin
    elig0       = reset_n & (m0.read | m0.write) & ~block0;
    elig1       = reset_n & (m1.read | m1.write) & ~block1;
    grant0      = elig0 & (~elig1 | last_grant);
    grant1      = elig1 & (~elig0 | ~last_grant);
    sel         = grant1;
    any_grant   = grant0 | grant1;
    sel_write   = sel ? m1.write : m0.write;
    sel_address = sel ? m1.address : m0.address;
    in_range    = {1'b0, sel_address} < LIMIT;
  end

  assign mem_address    = sel_address;
  assign mem_byteenable = sel ? m1.byteenable : m0.byteenable;
  assign mem_writedata  = sel ? m1.writedata : m0.writedata;
  assign mem_write      = any_grant & sel_write;
  assign mem_chipselect = any_grant & in_range;
  assign mem_clken      = 1'b1;

  assign m0.waitrequest = ~grant0;
  assign m1.waitrequest = ~grant1;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_grant <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_id     <= 1'b0;
      rsp_err    <= 1'b0;
      err_oor    <= 1'b0;
    end else begin
      rsp_valid <= any_grant & ~sel_write;
      if (any_grant) begin
        last_grant <= sel;
        if (!sel_write) begin
          rsp_id  <= sel;
          rsp_err <= ~in_range;
        end
        if (!in_range) err_oor <= 1'b1;
      end
    end
  end

  // RAM q is unregistered, so the response cycle passes it straight through.
  assign m0.readdatavalid = rsp_valid & ~rsp_id;
  assign m1.readdatavalid = rsp_valid & rsp_id;
  assign m0.readdata      = (rsp_valid & ~rsp_id & ~rsp_err) ? mem_readdata : '0;
  assign m1.readdata      = (rsp_valid & rsp_id & ~rsp_err) ? mem_readdata : '0;
  assign m0.response      = rsp_err ? 2'b10 : 2'b00;
  assign m1.response      = rsp_err ? 2'b10 : 2'b00;
endmodule

// File: tb/tb_onchip_mem_arbiter.sv
// tb/tb_onchip_mem_arbiter.sv - scoreboard bench for onchip_mem_arbiter with behavioural RAM and arbiter model
module tb_onchip_mem_arbiter;
  localparam int DEPTH = 37500;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  onchip_mem_arbiter_if m0_if ();
  onchip_mem_arbiter_if m1_if ();

  logic [15:0] mem_address;
  logic        mem_chipselect, mem_write, mem_clken, err_oor;
  logic [3:0]  mem_byteenable;
  logic [31:0] mem_writedata, mem_readdata;

  onchip_mem_arbiter dut (
    .clk(clk), .reset_n(reset_n), .m0(m0_if), .m1(m1_if),
    .mem_address(mem_address), .mem_chipselect(mem_chipselect), .mem_write(mem_write),
    .mem_clken(mem_clken), .mem_byteenable(mem_byteenable), .mem_writedata(mem_writedata),
    .mem_readdata(mem_readdata), .err_oor(err_oor)
  );

  // RAM environment: registered address, unregistered q
  bit [31:0] ram [DEPTH];
  bit [15:0] ram_addr_q;
  always @(posedge clk) begin
    if (mem_chipselect && mem_clken) begin
      if (mem_write)
        for (int b = 0; b < 4; b++)
          if (mem_byteenable[b]) ram[mem_address][8*b +: 8] <= mem_writedata[8*b +: 8];
      ram_addr_q <= mem_address;
    end
  end
  assign mem_readdata = ram[ram_addr_q];

  int n_checks = 0;
  int n_pass = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", nm, act, exp, $time);
  endtask

  task automatic bad(string nm);
    n_checks++;
    $display("FAIL %s: bound expired at t=%0t", nm, $time);
  endtask

  typedef struct {int id; logic [31:0] data; logic [1:0] resp; int cyc;} exp_t;
  exp_t sbq[$];

  // Reference model state
  logic [31:0] mdl[int];
  int  mdl_last = 1;
  int  owner = -1;
  bit  mdl_err = 0;
  bit  in_rst = 1;
  bit  ovr_v = 0;
  logic [31:0] ovr_d;
  int  last_g;
  bit  dut_acc0;

  bit          rq_rd[2], rq_wr[2], rq_lock[2];
  logic [15:0] rq_addr[2];
  logic [3:0]  rq_be[2];
  logic [31:0] rq_wd[2];

  function automatic logic [31:0] rdm(int a);
    return mdl.exists(a) ? mdl[a] : 32'h0;
  endfunction

  function automatic int predict();
    bit r0, r1;
    r0 = !in_rst && (rq_rd[0] || rq_wr[0]);
    r1 = !in_rst && (rq_rd[1] || rq_wr[1]);
    if (owner == 0) r1 = 0;
    if (owner == 1) r0 = 0;
    if (r0 && r1) return (mdl_last == 1) ? 0 : 1;
    if (r0) return 0;
    if (r1) return 1;
    return -1;
  endfunction

  task automatic apply();
    m0_if.read = rq_rd[0]; m0_if.write = rq_wr[0]; m0_if.address = rq_addr[0];
    m0_if.byteenable = rq_be[0]; m0_if.writedata = rq_wd[0];
    m1_if.read = rq_rd[1]; m1_if.write = rq_wr[1]; m1_if.address = rq_addr[1];
    m1_if.byteenable = rq_be[1]; m1_if.writedata = rq_wd[1];
`ifdef ONCHIP_MEM_ARB_LOCK_EN
    m0_if.lock = rq_lock[0];
    m1_if.lock = rq_lock[1];
`endif
  endtask

  task automatic step();
    int g; bit wr, inr; logic [15:0] a; logic [31:0] d; exp_t e;
    apply();
    @(negedge clk);
    g = predict();
    dut_acc0 = !m0_if.waitrequest;
    chk("wait_m0", m0_if.waitrequest, g != 0);
    chk("wait_m1", m1_if.waitrequest, g != 1);
    chk("err_oor", err_oor, mdl_err);
    wr = 0; inr = 0; a = 0;
    if (g >= 0) begin wr = rq_wr[g]; a = rq_addr[g]; inr = (int'(a) < DEPTH); end
    chk("chipselect", mem_chipselect, g >= 0 && inr);
    if (g >= 0) begin
      chk("mem_write", mem_write, wr);
      if (inr) chk("mem_address", mem_address, a);
      mdl_last = g;
      if (!inr) mdl_err = 1;
      if (wr) begin
        if (inr) begin
          d = rdm(a);
          for (int b = 0; b < 4; b++) if (rq_be[g][b]) d[8*b +: 8] = rq_wd[g][8*b +: 8];
          mdl[a] = d;
        end
      end else begin
        e.id = g; e.data = inr ? rdm(a) : 32'h0; e.resp = inr ? 2'b00 : 2'b10; e.cyc = cyc + 1;
        if (ovr_v) begin e.data = ovr_d; ovr_v = 0; end
        sbq.push_back(e);
      end
      if (rq_lock[g]) owner = g;
      else if (owner == g) owner = -1;
      rq_rd[g] = 0; rq_wr[g] = 0;
    end
    last_g = g;
    @(posedge clk); #1;
  endtask

  task automatic do_access(int n, bit rd, bit wr, logic [15:0] a, logic [3:0] be, logic [31:0] wd);
    rq_rd[n] = rd; rq_wr[n] = wr; rq_addr[n] = a; rq_be[n] = be; rq_wd[n] = wd;
    for (int i = 0; i < 20 && (rq_rd[n] || rq_wr[n]); i++) step();
    if (rq_rd[n] || rq_wr[n]) begin bad("accept_timeout"); rq_rd[n] = 0; rq_wr[n] = 0; end
  endtask

  task automatic drain();
    for (int i = 0; i < 40 && (rq_rd[0] || rq_wr[0] || rq_rd[1] || rq_wr[1]); i++) step();
    if (rq_rd[0] || rq_wr[0] || rq_rd[1] || rq_wr[1]) begin
      bad("drain_timeout"); rq_rd = '{0, 0}; rq_wr = '{0, 0};
    end
  endtask

  // Monitor: pops one expectation whenever a response is due, flags any unexpected strobe
  always @(negedge clk) begin
    exp_t e; bit due;
    due = (sbq.size() > 0) && (sbq[0].cyc == cyc);
    if (due) begin
      e = sbq.pop_front();
      chk("rdv_m0", m0_if.readdatavalid, e.id == 0);
      chk("rdv_m1", m1_if.readdatavalid, e.id == 1);
      if (e.id == 0) begin
        chk("rdata_m0", m0_if.readdata, e.data);
        chk("resp_m0", m0_if.response, e.resp);
        chk("rdata_m1_idle", m1_if.readdata, 0);
      end else begin
        chk("rdata_m1", m1_if.readdata, e.data);
        chk("resp_m1", m1_if.response, e.resp);
        chk("rdata_m0_idle", m0_if.readdata, 0);
      end
    end else if (m0_if.readdatavalid || m1_if.readdatavalid) begin
      chk("spurious_rdv", {m1_if.readdatavalid, m0_if.readdatavalid}, 0);
    end
  end

  initial begin
    int r, k;
    rq_rd = '{0, 0}; rq_wr = '{0, 0}; rq_lock = '{0, 0};
    rq_addr = '{0, 0}; rq_be = '{0, 0}; rq_wd = '{0, 0};
    apply();

    // Reset state, with a request held to show waitrequest is forced
    rq_rd[0] = 1; rq_addr[0] = 16'h3; rq_be[0] = 4'hF;
    step();
    chk("rst_rdv_m0", m0_if.readdatavalid, 0);
    chk("rst_rdata_m0", m0_if.readdata, 0);
    chk("rst_resp_m0", m0_if.response, 0);
    step();
    reset_n = 1; in_rst = 0;
    drain();

    // Single write then read
    do_access(0, 0, 1, 16'h0010, 4'hF, 32'hA5A5_1234);
    ovr_v = 1; ovr_d = 32'hA5A5_1234;
    do_access(0, 1, 0, 16'h0010, 4'hF, 0);

    // Byte lanes
    do_access(1, 0, 1, 16'd5, 4'hF, 32'hFFFF_FFFF);
    do_access(1, 0, 1, 16'd5, 4'b0101, 32'h0000_0000);
    ovr_v = 1; ovr_d = 32'hFF00_FF00;
    do_access(0, 1, 0, 16'd5, 4'hF, 0);
    step();

    // Contention: both masters read continuously
    for (int c = 0; c < 12; c++) begin
      for (int n = 0; n < 2; n++)
        if (!rq_rd[n]) begin rq_rd[n] = 1; rq_addr[n] = 16'($urandom_range(0, 15)); rq_be[n] = 4'hF; end
      step();
    end
    drain();

    // Out-of-range read
    do_access(1, 1, 0, 16'd37500, 4'hF, 0);
    step(); step();

    // Reset in the cycle after a read acceptance
    do_access(0, 1, 0, 16'h0010, 4'hF, 0);
    reset_n = 0; in_rst = 1; sbq.delete(); mdl_last = 1; mdl_err = 0; owner = -1;
    rq_rd[0] = 1; rq_addr[0] = 16'h1; rq_be[0] = 4'hF;
    rq_rd[1] = 1; rq_addr[1] = 16'h2; rq_be[1] = 4'hF;
    step(); step();
    reset_n = 1; in_rst = 0;
    step();
    chk("post_rst_m0_wins", dut_acc0, 1);
    drain();

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      for (int n = 0; n < 2; n++)
        if (!(rq_rd[n] || rq_wr[n]) && $urandom_range(0, 9) < 6) begin
          r = $urandom_range(0, 3);
          rq_rd[n] = (r != 2); rq_wr[n] = (r >= 2);
          k = $urandom_range(0, 19);
          if (k < 16) rq_addr[n] = 16'(k);
          else if (k == 16) rq_addr[n] = 16'(DEPTH - 1);
          else if (k == 17) rq_addr[n] = 16'(DEPTH);
          else rq_addr[n] = 16'($urandom_range(DEPTH, 65535));
          rq_be[n] = 4'($urandom_range(0, 15));
          rq_wd[n] = $urandom;
        end
      step();
    end
    drain();

`ifdef ONCHIP_MEM_ARB_LOCK_EN
    begin
      int m0_early;
      m0_early = 0;
      for (int j = 0; j < 4; j++) begin
        rq_wr[1] = 1; rq_rd[1] = 0; rq_addr[1] = 16'(20 + j); rq_be[1] = 4'hF;
        rq_wd[1] = $urandom; rq_lock[1] = (j < 3);
        if (j == 1) begin rq_rd[0] = 1; rq_addr[0] = 16'd20; rq_be[0] = 4'hF; end
        for (int i = 0; i < 10 && rq_wr[1]; i++) begin
          step();
          if (dut_acc0) m0_early++;
        end
      end
      rq_lock[1] = 0;
      chk("lock_m0_held", m0_early, 0);
      step();
      chk("lock_m0_after", dut_acc0, 1);
      drain();
    end
`endif

    step(); step(); step();
    chk("sb_drained", sbq.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Two-master round-robin arbiter in front of the single-port 32-bit on-chip RAM: 16-bit word address, byte enables, registered address, unregistered q.
- Lets the Nios data master (m0) and the sensor/WiFi DMA master (m1) share the RAM at one access per cycle.
- Returns read data with a fixed 1-cycle pipelined latency and flags out-of-range accesses.
- Sits between the Avalon-MM masters and the RAM slave port.

Parameters:
- ADDR_W, 16, word address width
- DATA_W, 32, data width; byte-enable width is DATA_W/8
- DEPTH, 37500, number of implemented words; legal addresses are 0..DEPTH-1

Ports:
- clk  in  1  single clock
- reset_n  in  1  asynchronous, active-low reset
- mN_address  in  ADDR_W  master N word address (N=0,1)
- mN_read / mN_write  in  1 each  master N read / write request
- mN_byteenable  in  DATA_W/8  master N byte enables
- mN_writedata  in  DATA_W  master N write data
- mN_waitrequest  out  1  high = request not accepted this cycle
- mN_readdata  out  DATA_W  read data
- mN_readdatavalid  out  1  read data valid strobe
- mN_response  out  2  00 OKAY, 10 SLAVEERROR; valid with readdatavalid
- mem_address  out  ADDR_W  to RAM
- mem_chipselect, mem_write, mem_clken  out  1 each  to RAM
- mem_byteenable  out  DATA_W/8  to RAM
- mem_writedata  out  DATA_W  to RAM
- mem_readdata  in  DATA_W  RAM q, valid 1 cycle after address
- err_oor  out  1  sticky out-of-range flag

Behaviour:
- Request: reqN = mN_read | mN_write. If both bits are set on one master, the write wins and the read is ignored.
- Grant is combinational and at most one per cycle.
  - Only one requester: it is granted.
  - Both requesting: grant goes to the master other than last_grant.
  - last_grant register updates on every grant; reset value 1, so m0 wins the first contention.
- mN_waitrequest = ~grantN. Forced 1 while reset_n is low.
- Accepted means grant with waitrequest low in that cycle. The master must hold its request until accepted.
- Forwarding, same cycle as grant:
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_write = granted write.
  - mem_chipselect = grant & in-range.
  - mem_clken held 1.
- Out of range (address >= DEPTH):
  - Request is accepted but not forwarded.
  - err_oor sets and stays set until reset.
  - Write: dropped.
  - Read: completes with readdata 0 and response 10.
- Read response pipeline, registered:
  - rsp_valid, rsp_id, rsp_err load on each accepted read.
  - Next cycle: mN_readdatavalid = rsp_valid & (rsp_id==N).
  - mN_readdata = (rsp_err ? 0 : mem_readdata) when this master is the response target, else 0.
  - mN_response = rsp_err ? 10 : 00.
- Latency and throughput:
  - Read latency is exactly 1 cycle after acceptance.
  - Back-to-back reads (same or alternating master) give one readdatavalid per cycle in acceptance order.
- Write followed by read of the same address in the next cycle returns the new data. The RAM write completes before the read address registers.
- Reset values: all readdatavalid 0, response 00, readdata 0, rsp_valid 0, err_oor 0, last_grant 1.
- Reset mid-operation: a pending read response is discarded, no readdatavalid is emitted after reset release, and grants restart from m0 priority.

Optional Feature:
- Macro: ONCHIP_MEM_ARB_LOCK_EN.
- Defined:
  - Adds inputs m0_lock and m1_lock.
  - An accepted access with mN_lock=1 makes N the owner. The other master is held in waitrequest every cycle until N completes an accepted access with mN_lock=0, which releases ownership after that access.
  - Round-robin resumes with last_grant=N.
  - Lock state clears on reset.
- Undefined: lock ports do not exist and arbitration is pure round-robin.

Test Plan:
- Single write then read: m0 writes 0xA5A5_1234 to addr 0x0010 (byteenable 1111), then reads 0x0010 → m0_readdatavalid exactly 1 cycle after read acceptance with data 0xA5A5_1234, response 00.
- Byte lanes: write 0xFFFF_FFFF to addr 5, then write 0x0000_0000 with byteenable 0101 → read returns 0xFF00_FF00.
- Contention: m0 and m1 read continuously from cycle 0 → grants alternate m0,m1,m0,…, each master gets a readdatavalid every other cycle, and the other master's readdatavalid is never high.
- Out-of-range read: m1 reads addr 37500 → mem_chipselect stays 0, m1_readdata=0, response 10 one cycle later, err_oor=1 and stays high.
- Reset mid-read: assert reset_n low in the cycle after m0 read acceptance → no readdatavalid ever appears for that read, and after release m0 wins a simultaneous request.
- LOCK_EN: m1 does 3 locked writes then 1 unlocked write while m0 requests throughout → m0 is granted only after the 4th m1 acceptance.
